// File: rtl/seg7_disp_arbiter_pkg.sv
// Shared types and constants for the seven-segment display arbiter.
// Holds the controller state enum, the display data width and a counter-width helper.
package seg7_disp_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        LAMP,
        IDLE,
        SHOW,
        HOLD
    } disp_state_t;

    // Width of a counter that must hold values 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seg7_disp_arbiter_if.sv
// Requester-side bundle for the display arbiter: request, value, blink flag and grant.
// The master modport is the requester side; the slave modport is the arbiter.
interface seg7_disp_arbiter_if
    import seg7_disp_pkg::*;
#(
    parameter int NREQ = 2
) ();

    logic [NREQ-1:0]             req;
    logic [NREQ-1:0][DATA_W-1:0] req_data;
    logic [NREQ-1:0]             req_alert;
    logic [NREQ-1:0]             gnt;

    modport master (output req, output req_data, output req_alert, input gnt);
    modport slave  (input req, input req_data, input req_alert, output gnt);

endinterface

// File: rtl/seg7_disp_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr wins.
// Produces a one-hot grant and the matching index; outputs are zero when nobody requests.
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   idx
);

    int   j;
    logic found;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int i = 0; i < NREQ; i++) begin
            j = int'(ptr) + i;
            if (j >= NREQ) j = j - NREQ;
            if (!found && req[j]) begin
                found  = 1'b1;
                gnt[j] = 1'b1;
                idx    = IW'(j);
            end
        end
    end

endmodule

// File: rtl/seg7_disp_arbiter.sv
// Shares one dual hex-digit display between NREQ requesters with round-robin ownership and dwell.
// Optional blink of the owner's value is built only when DISP_BLINK_EN is defined.
//
// state | meaning
// LAMP  | lamp test after reset (test=1), requests left pending
// IDLE  | display blanked, waiting for the first request
// SHOW  | owner within its minimum dwell; only owner updates accepted
// HOLD  | dwell served; any other requester may take over, display stays lit
module seg7_disp_arbiter
    import seg7_disp_pkg::*;
#(
    parameter int NREQ         = 2,
    parameter int DWELL_CYCLES = 50_000_000,
    parameter int TEST_CYCLES  = 25_000_000,
    parameter int BLINK_HALF   = 12_500_000
) (
    input  logic                    clk,
    input  logic                    reset,
    seg7_disp_arbiter_if.slave      rq,
    output logic                    blank,
    output logic                    test,
    output logic [DATA_W-1:0]       data,
    output logic [$clog2(NREQ)-1:0] owner,
    output logic                    busy
);

    localparam int IW   = $clog2(NREQ);
    localparam int DW_W = cnt_w(DWELL_CYCLES);
    localparam int TW   = cnt_w(TEST_CYCLES + 1);

    disp_state_t       state_q, state_d;
    logic [TW-1:0]     lamp_q, lamp_d;
    logic [DW_W-1:0]   dwell_q, dwell_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [IW-1:0]     owner_q, owner_d;
    logic              blank_q, blank_d;
    logic              test_q, test_d;
    logic              busy_q, busy_d;

    logic [NREQ-1:0]   arb_gnt;
    logic [IW-1:0]     arb_idx;
    logic              do_grant;
    logic [IW-1:0]     win;
    logic [NREQ-1:0]   win_oh;
    disp_state_t       grant_state;

    rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr_arbiter (
        .req  (rq.req),
        .ptr  (ptr_q),
        .gnt  (arb_gnt),
        .idx  (arb_idx)
    );

    // A dwell of one cycle is already served at the grant edge.
    assign grant_state = (DWELL_CYCLES > 1) ? SHOW : HOLD;

    always_comb begin
        state_d  = state_q;
        lamp_d   = lamp_q;
        dwell_d  = dwell_q;
        ptr_d    = ptr_q;
        gnt_d    = '0;
        data_d   = data_q;
        owner_d  = owner_q;
        do_grant = 1'b0;
        win      = arb_idx;
        win_oh   = arb_gnt;

        case (state_q)
            LAMP: begin
                if (lamp_q == '0) state_d = IDLE;
                else              lamp_d  = lamp_q - 1'b1;
            end
            IDLE: begin
                if (|rq.req) begin
                    do_grant = 1'b1;
                    state_d  = grant_state;
                    dwell_d  = '0;
                end
            end
            SHOW: begin
                if (rq.req[owner_q]) begin
                    do_grant        = 1'b1;
                    win             = owner_q;
                    win_oh          = '0;
                    win_oh[owner_q] = 1'b1;
                end
                dwell_d = dwell_q + 1'b1;
                if (dwell_d == DW_W'(DWELL_CYCLES - 1)) state_d = HOLD;
            end
            HOLD: begin
                // Pointer sits at owner+1, so the owner only wins when alone.
                if (|rq.req) begin
                    do_grant = 1'b1;
                    if (arb_idx != owner_q) begin
                        state_d = grant_state;
                        dwell_d = '0;
                    end
                end
            end
            default: state_d = LAMP;
        endcase

        if (do_grant) begin
            gnt_d   = win_oh;
            data_d  = rq.req_data[win];
            owner_d = win;
            ptr_d   = (win == IW'(NREQ - 1)) ? '0 : win + 1'b1;
        end
    end

`ifdef DISP_BLINK_EN
    localparam int BW = cnt_w(BLINK_HALF);

    logic          alert_q, alert_d;
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic          ph_q, ph_d;

    always_comb begin
        alert_d = alert_q;
        bcnt_d  = bcnt_q;
        ph_d    = ph_q;
        if (do_grant) begin
            alert_d = rq.req_alert[win];
            bcnt_d  = BW'(BLINK_HALF - 1);
            ph_d    = 1'b0;
        end else if (state_q == SHOW || state_q == HOLD) begin
            if (bcnt_q == '0) begin
                ph_d   = ~ph_q;
                bcnt_d = BW'(BLINK_HALF - 1);
            end else begin
                bcnt_d = bcnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alert_q <= 1'b0;
            bcnt_q  <= '0;
            ph_q    <= 1'b0;
        end else begin
            alert_q <= alert_d;
            bcnt_q  <= bcnt_d;
            ph_q    <= ph_d;
        end
    end
`else
    logic unused_alert;
    assign unused_alert = ^rq.req_alert;
`endif

    always_comb begin
        test_d  = (state_d == LAMP);
        busy_d  = (state_d == SHOW) || (state_d == HOLD);
        blank_d = (state_d == IDLE);
`ifdef DISP_BLINK_EN
        if (busy_d) blank_d = alert_d & ph_d;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= LAMP;
            lamp_q  <= TW'(TEST_CYCLES);
            dwell_q <= '0;
            ptr_q   <= '0;
            gnt_q   <= '0;
            data_q  <= '0;
            owner_q <= '0;
            blank_q <= 1'b1;
            test_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lamp_q  <= lamp_d;
            dwell_q <= dwell_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            data_q  <= data_d;
            owner_q <= owner_d;
            blank_q <= blank_d;
            test_q  <= test_d;
            busy_q  <= busy_d;
        end
    end

    assign rq.gnt = gnt_q;
    assign blank  = blank_q;
    assign test   = test_q;
    assign data   = data_q;
    assign owner  = owner_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_seg7_disp_arbiter.sv
// Scoreboard bench for seg7_disp_arbiter with NREQ=2, DWELL=4, TEST=3, BLINK_HALF=2.
// Expected grants are queued when requests are driven and popped when gnt pulses.
module tb_seg7_disp_arbiter;

    typedef struct {
        int         idx;
        logic [7:0] d;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       blank;
    logic       test;
    logic [7:0] data;
    logic       owner;
    logic       busy;

    int   n_vec = 0;
    int   n_err = 0;
    exp_t sb[$];
    logic [5:0] blink_exp;

    seg7_disp_arbiter_if #(.NREQ(2)) rq ();

    seg7_disp_arbiter #(
        .NREQ         (2),
        .DWELL_CYCLES (4),
        .TEST_CYCLES  (3),
        .BLINK_HALF   (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .rq    (rq),
        .blank (blank),
        .test  (test),
        .data  (data),
        .owner (owner),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input int idx, input logic [7:0] d);
        exp_t e;
        e.idx = idx;
        e.d   = d;
        sb.push_back(e);
    endtask

    task automatic post(input int idx, input logic [7:0] d, input logic alert);
        rq.req_data[idx]  = d;
        rq.req_alert[idx] = alert;
        rq.req[idx]       = 1'b1;
        push(idx, d);
    endtask

    // Waits for gnt[i], drops req[i] in the following cycle, checks the latency.
    task automatic wait_gnt(input int i, input string tag, input int exp_cyc);
        int   cyc  = 0;
        logic seen = 1'b0;
        while (!seen && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (rq.gnt[i]) seen = 1'b1;
        end
        rq.req[i] = 1'b0;
        chk(tag, cyc, exp_cyc);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rq.gnt != '0) begin
            if (sb.size() == 0) begin
                chk("gnt_unexpected", rq.gnt, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("gnt_onehot", rq.gnt, 32'd1 << e.idx);
                chk("gnt_data", data, e.d);
                chk("gnt_owner", owner, e.idx);
                chk("gnt_busy", busy, 1);
                chk("gnt_blank", blank, 0);
            end
        end
    end

    initial begin
`ifdef DISP_BLINK_EN
        blink_exp = 6'b001100;
`else
        blink_exp = 6'b000000;
`endif
        reset        = 1'b1;
        rq.req       = '0;
        rq.req_data  = '0;
        rq.req_alert = '0;
        #3;
        chk("rst_blank", blank, 1);
        chk("rst_test", test, 0);
        chk("rst_data", data, 0);
        chk("rst_gnt", rq.gnt, 0);
        chk("rst_owner", owner, 0);
        chk("rst_busy", busy, 0);

        // Lamp test then blank idle.
        @(negedge clk);
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("lamp_test", test, 1);
            chk("lamp_blank", blank, 0);
        end
        @(negedge clk);
        chk("idle_test", test, 0);
        chk("idle_blank", blank, 1);
        chk("idle_busy", busy, 0);

        // Request held through LAMP is granted on the first IDLE cycle.
        do_reset();
        post(0, 8'h3A, 1'b0);
        wait_gnt(0, "lamp_pending_lat", 5);

        // Simultaneous requests in IDLE, then HOLD handover behaviour.
        do_reset();
        repeat (4) @(negedge clk);
        post(0, 8'h11, 1'b0);
        post(1, 8'h22, 1'b0);
        wait_gnt(0, "idle_lat", 1);
        wait_gnt(1, "dwell_handover", 4);
        repeat (3) @(negedge clk);
        post(0, 8'h44, 1'b0);
        post(1, 8'h66, 1'b0);
        wait_gnt(0, "hold_other_wins", 1);
        wait_gnt(1, "hold_owner_waits", 4);
        repeat (3) @(negedge clk);
        post(1, 8'h77, 1'b0);
        wait_gnt(1, "hold_owner_update", 1);
        post(0, 8'h88, 1'b0);
        wait_gnt(0, "still_hold_lat", 1);
        // A request dropped before its grant is lost.
        rq.req[1] = 1'b1;
        @(negedge clk);
        rq.req[1] = 1'b0;
        repeat (8) @(negedge clk);
        chk("hold_blank", blank, 0);
        chk("hold_busy", busy, 1);
        chk("hold_data", data, 8'h88);
        chk("hold_owner", owner, 0);

        // Owner update mid-dwell does not restart the dwell.
        do_reset();
        repeat (4) @(negedge clk);
        post(0, 8'h11, 1'b0);
        wait_gnt(0, "idle_lat2", 1);
        rq.req_data[1] = 8'h22;
        rq.req[1]      = 1'b1;
        @(negedge clk);
        rq.req_data[0] = 8'h55;
        rq.req[0]      = 1'b1;
        push(0, 8'h55);
        push(1, 8'h22);
        wait_gnt(0, "owner_update_lat", 1);
        wait_gnt(1, "orig_dwell_end", 2);

        // Asynchronous reset mid-SHOW.
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("arst_blank", blank, 1);
        chk("arst_data", data, 0);
        chk("arst_gnt", rq.gnt, 0);
        chk("arst_busy", busy, 0);
        chk("arst_test", test, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("relamp_test", test, 1);
        end
        @(negedge clk);
        chk("relamp_end", test, 0);
        chk("relamp_blank", blank, 1);

        // Blink with alert set, then alert cleared forces blank low.
        post(0, 8'h5C, 1'b1);
        wait_gnt(0, "alert_lat", 1);
        for (int k = 1; k < 6; k++) begin
            @(negedge clk);
            chk("blink_blank", blank, blink_exp[k]);
        end
        post(0, 8'h5D, 1'b0);
        wait_gnt(0, "noalert_lat", 1);
        repeat (4) begin
            @(negedge clk);
            chk("noalert_blank", blank, 0);
        end

        repeat (2) @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/seg7_disp_arbiter.md
# seg7_disp_arbiter

Shares one dual seven-segment display pair between several requesters, e.g. the soft microprocessor output port and the board switches. Requesters post 8-bit values with a valid/grant handshake. A round-robin arbiter picks one owner and holds it for a minimum dwell time. The block then drives the blank, test and 8-bit data inputs of the dual hex-digit decoder. After reset it runs a timed lamp test, then blanks the display until the first request arrives.

## Interface
- NREQ, 2: number of requesters, 2..8.
- DWELL_CYCLES, 50_000_000: minimum cycles an owner keeps the display before another requester can take it.
- TEST_CYCLES, 25_000_000: lamp-test length after reset.
- BLINK_HALF, 12_500_000: blink half-period in cycles (used only with DISP_BLINK_EN).
- clk  in  1  system clock; one clock domain.
- reset  in  1  asynchronous, active-high reset.
- req  in  NREQ  per-requester request, held until granted.
- req_data  in  NREQ×8  per-requester display value; high nibble goes to the left digit, low nibble to the right digit.
- req_alert  in  NREQ  per-requester blink request.
- gnt  out  NREQ  one-hot, single-cycle pulse; req_data was latched on this edge.
- blank  out  1  to decoder blank input.
- test  out  1  to decoder test input.
- data  out  8  to decoder data input.
- owner  out  $clog2(NREQ)  index of the current owner.
- busy  out  1  a requester owns the display.

## Operation
- Reset values, applied asynchronously: blank=1, test=0, data=0, gnt=0, owner=0, busy=0, round-robin pointer=0, state LAMP.
- LAMP:
  - test=1, blank=0 for exactly TEST_CYCLES cycles after reset deasserts; then go to IDLE.
  - Requests are not granted in LAMP; they stay pending.
- IDLE:
  - blank=1, busy=0.
  - On any req, grant the winner and go to SHOW.
- SHOW:
  - blank=0, busy=1, and the dwell counter counts up.
  - The current owner may re-request at any time: it gets a gnt pulse and data updates. The dwell counter does not restart.
  - Other requests wait.
  - When the counter reaches DWELL_CYCLES-1, go to HOLD.
- HOLD:
  - Keep showing the owner's data.
  - If any other requester has req set, grant it, reset the dwell counter and go to SHOW.
  - If the owner alone has req set, accept its update and stay in HOLD.
  - The display never blanks once it has been written; it stays in HOLD with no requests.
- Arbitration:
  - Round-robin starting at pointer = last owner+1 (mod NREQ).
  - Among simultaneous requesters, the first index at or after the pointer wins.
  - In HOLD, the owner competes only if no one else requests.
- A grant latches req_data[winner] into data, sets owner, pulses gnt[winner] for one cycle and moves the pointer.
- A requester must drop req in the cycle after its gnt, or the arbiter treats it as a new request.

## Timing
- Grant latency: req is sampled high at edge N; gnt, data and owner update at edge N+1. This is one cycle in IDLE, in HOLD, or for an owner update.
- Outputs are registered; there is no combinational path from req to any output.
- A reset in any state returns to LAMP immediately, with outputs at their reset values. Pending requests are forgotten.
- A request that is dropped before it is granted is lost and produces no gnt.
- Dwell counter width is $clog2(DWELL_CYCLES). It saturates in HOLD and does not wrap.

## Configuration
- DISP_BLINK_EN defined:
  - In SHOW or HOLD, if the owner's req_alert was latched high at grant, blank toggles every BLINK_HALF cycles.
  - The blink phase starts with blank=0 at the grant.
  - A grant with alert=0 forces blank=0.
- DISP_BLINK_EN undefined: req_alert is ignored; no blink counter or logic is built.

## Structure
- Package seg7_disp_pkg holds:
  - the state enum disp_state_t {LAMP, IDLE, SHOW, HOLD};
  - the localparam for data width (8).
- Sub-module rr_arbiter:
  - inputs: NREQ request vector and pointer;
  - outputs: one-hot grant and index;
  - purely combinational.
- The top level instantiates the dual hex-digit decoder separately; this block does not contain it.

## Test plan
All scenarios use NREQ=2, DWELL_CYCLES=4, TEST_CYCLES=3, BLINK_HALF=2.
- Reset release with no requests -> test=1 for 3 cycles, then blank=1, test=0, busy=0.
- req[0] with data 0x3A asserted during LAMP -> no gnt during LAMP; gnt[0] pulses the cycle after LAMP ends; data=0x3A, blank=0.
- req[0]=0x11 and req[1]=0x22 together in IDLE with pointer=0 -> owner 0 shown first. req[1] stays high; gnt[1] follows 4 cycles after gnt[0]; data=0x22, owner=1.
- Owner 0 in SHOW re-requests 0x55 at dwell cycle 1 -> gnt[0] next cycle, data=0x55. Requester 1, pending, is still granted at the original dwell end.
- Reset asserted mid-SHOW -> blank=1, data=0, gnt=0 immediately (asynchronously); after release, LAMP runs for 3 cycles.
- DISP_BLINK_EN defined, grant with alert=1 -> blank follows 0,0,1,1,0,0 over six cycles. With the macro undefined, blank stays 0.
